// File: rtl/jk_reg_bank.sv
// jk_reg_bank: parametrised bank of JK flip-flops with a parallel load,
// a clock enable and up/down counting built from JK toggle mode.
// The wrap and chg status flags are registered with q.
module jk_reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             wrap,
  output logic             chg
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  mode_t            op;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             chg_next;
  logic             carry;

  assign op = mode_t'(mode);
  assign qn = ~q;

  // Next-state selection: load, then enable, then the operating mode.
  // Counting ripples a toggle enable upward: bit i toggles only when every
  // lower bit is 1 (up) or 0 (down).
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    carry     = 1'b1;
    if (load) begin
      q_next = d;
    end else if (en) begin
      case (op)
        MODE_JK: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
              2'b01:   q_next[i] = 1'b0;
              2'b10:   q_next[i] = 1'b1;
              2'b11:   q_next[i] = ~q[i];
              default: q_next[i] = q[i];
            endcase
          end
        end
        MODE_UP: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            q_next[i] = q[i] ^ carry;
            carry     = carry & q[i];
          end
          wrap_next = &q;
        end
        MODE_DN: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            q_next[i] = q[i] ^ carry;
            carry     = carry & ~q[i];
          end
          wrap_next = ~|q;
        end
        default: q_next = q;
      endcase
    end
    chg_next = (q_next != q);
  end

  // State and flag registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q    <= RESET_VAL;
      wrap <= 1'b0;
      chg  <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
      chg  <= chg_next;
    end
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: directed vector table plus hand-written clear sequences
// for jk_reg_bank at WIDTH=4, with a second instance using RESET_VAL=4'h5.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic       load;
  logic [3:0] d;
  logic [1:0] mode;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q,  qn;
  logic [3:0] q5, qn5;
  logic       wrap, chg, wrap5, chg5;

  int n_checks = 0;
  int n_fail   = 0;

  jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
    .clk(clk), .clr(clr), .en(en), .load(load), .d(d), .mode(mode),
    .j(j), .k(k), .q(q), .qn(qn), .wrap(wrap), .chg(chg)
  );

  jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'h5)) dut5 (
    .clk(clk), .clr(clr), .en(en), .load(load), .d(d), .mode(mode),
    .j(j), .k(k), .q(q5), .qn(qn5), .wrap(wrap5), .chg(chg5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic       en;
    logic [1:0] mode;
    logic [3:0] d;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] eq;
    logic       ew;
    logic       ec;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic l, input logic e, input logic [1:0] m,
                       input logic [3:0] dd, input logic [3:0] jj, input logic [3:0] kk);
    load = l; en = e; mode = m; d = dd; j = jj; k = kk;
  endtask

  // Advance one rising edge and sample shortly after it.
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            load  en    mode   d      j        k        q        wrap  chg
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 4'h0, 4'b1010, 4'b0000, 4'b1010, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 2'b00, 4'h0, 4'b1111, 4'b1111, 4'b0101, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 4'h0, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 4'h0, 4'b0000, 4'b0100, 4'b0001, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 4'h0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 2'b00, 4'hE, 4'b1111, 4'b1111, 4'b1110, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 4'h0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 4'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 2'b01, 4'h0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'b01, 4'h1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'b10, 4'h0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 2'b10, 4'h0, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 2'b10, 4'h0, 4'b0000, 4'b0000, 4'b1110, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 2'b01, 4'h3, 4'b0000, 4'b0000, 4'b0011, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 2'b01, 4'h8, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 2'b01, 4'h0, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 2'b11, 4'h0, 4'b1111, 4'b1111, 4'b1000, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 2'b01, 4'h0, 4'b0000, 4'b0000, 4'b1001, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 2'b10, 4'h0, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 2'b00, 4'hF, 4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 1'b1, 2'b01, 4'hF, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 2'b01, 4'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 2'b01, 4'h0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

    // Power-up clear.
    clr = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
    #12;
    check("reset q",     q,     4'h0);
    check("reset wrap",  {3'b0, wrap}, 4'h0);
    check("reset chg",   {3'b0, chg},  4'h0);
    check("reset q rv5", q5,    4'h5);
    clr = 1'b1;
    #1;
    check("release no edge q", q, 4'h0);

    // Load, then clear asynchronously mid-cycle.
    drive(1'b1, 1'b0, 2'b00, 4'hA, 4'h0, 4'h0);
    edge_sample();
    check("load 1010 q",   q,   4'hA);
    check("load 1010 chg", {3'b0, chg}, 4'h1);
    #2;
    clr = 1'b0;
    #1;
    check("async clr q",    q,  4'h0);
    check("async clr chg",  {3'b0, chg}, 4'h0);
    check("async clr q rv5", q5, 4'h5);

    // Clear held low across a rising edge with load pending.
    drive(1'b1, 1'b0, 2'b00, 4'hF, 4'h0, 4'h0);
    edge_sample();
    check("clr over edge q",    q,  4'h0);
    check("clr over edge q rv5", q5, 4'h5);
    check("clr over edge wrap", {3'b0, wrap}, 4'h0);
    #2;
    clr = 1'b1;
    #1;
    check("clr release q", q, 4'h0);
    @(negedge clk);
    check("falling edge q", q, 4'h0);
    edge_sample();
    check("load after clr q",     q,  4'hF);
    check("load after clr q rv5", q5, 4'hF);
    check("load after clr chg",   {3'b0, chg}, 4'h1);

    // Return to zero before the vector table.
    #2;
    clr = 1'b0;
    #2;
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
    clr = 1'b1;
    #1;
    check("table start q", q, 4'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].load, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].j, vecs[i].k);
      edge_sample();
      check($sformatf("vec%0d q", i),    q,    vecs[i].eq);
      check($sformatf("vec%0d qn", i),   qn,   ~vecs[i].eq);
      check($sformatf("vec%0d wrap", i), {3'b0, wrap}, {3'b0, vecs[i].ew});
      check($sformatf("vec%0d chg", i),  {3'b0, chg},  {3'b0, vecs[i].ec});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
